user_pulse_monitor: RTL

- Downstream consumer of the user-domain pulse generator: samples its `pulse_o` and `state_o`.
- Measures each pulse period (high width, low width in clk cycles) and streams one record per period over a valid/ready interface to the register/DMA side.
- Keeps running statistics: rising-edge count, min/max high width, overrun flag.
- Finalises the run when the generator reports DONE.

---
 rtl/user_pulse_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/user_pulse_monitor.sv
// Pulse period monitor: measures high/low widths of the generator's pulse stream,
// streams one record per period over valid/ready and keeps run statistics.
module user_pulse_monitor #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [2:0]  DONE_ENC = 3'd4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             clear_i,
    input  logic             pulse_i,
    input  logic [2:0]       state_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [WIDTH-1:0] meas_high_o,
    output logic [WIDTH-1:0] meas_low_o,
    output logic             meas_last_o,
    output logic [WIDTH-1:0] pulse_count_o,
    output logic [WIDTH-1:0] min_high_o,
    output logic [WIDTH-1:0] max_high_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_HIGH,
        S_LOW,
        S_FINISHED
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    state_t           state, state_n;
    logic             pulse_q;
    logic             rise, fall;
    logic [WIDTH-1:0] hi_cnt, hi_cnt_n;
    logic [WIDTH-1:0] lo_cnt, lo_cnt_n;
    logic [WIDTH-1:0] pulse_count, pulse_count_n;
    logic             stat_clr;
    logic             done_set;
    logic             rec_gen;
    logic [WIDTH-1:0] rec_high, rec_low;
    logic             rec_last;
    logic             xfer;
    logic             run_done;

    assign rise     = pulse_i & ~pulse_q;
    assign fall     = ~pulse_i & pulse_q;
    assign xfer     = meas_valid_o & meas_ready_i;
    assign run_done = (state_i == DONE_ENC);

    always_comb begin
        state_n       = state;
        hi_cnt_n      = hi_cnt;
        lo_cnt_n      = lo_cnt;
        pulse_count_n = pulse_count;
        stat_clr      = 1'b0;
        done_set      = 1'b0;
        rec_gen       = 1'b0;
        rec_high      = hi_cnt;
        rec_low       = lo_cnt;
        rec_last      = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm_i) begin
                    state_n       = S_WAIT_RISE;
                    stat_clr      = 1'b1;
                    hi_cnt_n      = '0;
                    lo_cnt_n      = '0;
                    pulse_count_n = '0;
                end
            end
            S_FINISHED: begin
                if (!arm_i) state_n = S_IDLE;
            end
            default: begin
                if (!arm_i) begin
                    state_n = S_IDLE;
                end else if (run_done) begin
                    // Run end wins over any edge seen in the same cycle.
                    state_n  = S_FINISHED;
                    done_set = 1'b1;
                    if (state == S_HIGH) begin
                        rec_gen  = 1'b1;
                        rec_low  = '0;
                        rec_last = 1'b1;
                    end else if (state == S_LOW) begin
                        rec_gen  = 1'b1;
                        rec_last = 1'b1;
                    end
                end else begin
                    case (state)
                        S_WAIT_RISE: begin
                            if (rise) begin
                                state_n       = S_HIGH;
                                hi_cnt_n      = ONE;
                                pulse_count_n = sat_inc(pulse_count);
                            end
                        end
                        S_HIGH: begin
                            if (fall) begin
                                state_n  = S_LOW;
                                lo_cnt_n = ONE;
                            end else if (pulse_i) begin
                                hi_cnt_n = sat_inc(hi_cnt);
                            end
                        end
                        S_LOW: begin
                            if (rise) begin
                                rec_gen       = 1'b1;
                                state_n       = S_HIGH;
                                hi_cnt_n      = ONE;
                                pulse_count_n = sat_inc(pulse_count);
                            end else begin
                                lo_cnt_n = sat_inc(lo_cnt);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= S_IDLE;
            pulse_q      <= 1'b0;
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            pulse_count  <= '0;
            min_high_o   <= '1;
            max_high_o   <= '0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
            meas_valid_o <= 1'b0;
            meas_high_o  <= '0;
            meas_low_o   <= '0;
            meas_last_o  <= 1'b0;
        end else begin
            state       <= state_n;
            pulse_q     <= pulse_i;
            hi_cnt      <= hi_cnt_n;
            lo_cnt      <= lo_cnt_n;
            pulse_count <= pulse_count_n;
            if (stat_clr) begin
                min_high_o   <= '1;
                max_high_o   <= '0;
                done_o       <= 1'b0;
                overrun_o    <= 1'b0;
                meas_valid_o <= 1'b0;
            end else begin
                if (rec_gen) begin
                    // Statistics track every generated record, even a dropped one.
                    if (rec_high < min_high_o) min_high_o <= rec_high;
                    if (rec_high > max_high_o) max_high_o <= rec_high;
                    if (!meas_valid_o || xfer) begin
                        meas_valid_o <= 1'b1;
                        meas_high_o  <= rec_high;
                        meas_low_o   <= rec_low;
                        meas_last_o  <= rec_last;
                    end else begin
                        overrun_o <= 1'b1;
                    end
                end else if (xfer) begin
                    meas_valid_o <= 1'b0;
                end
                if (done_set) done_o <= 1'b1;
            end
        end
    end

    assign pulse_count_o = pulse_count;
    assign busy_o        = (state == S_WAIT_RISE) || (state == S_HIGH) || (state == S_LOW);

endmodule
